// File: rtl/z80_bus_responder.sv
// z80_bus_responder
// Memory/IO slave for the Z80 bus driven by tv80n_wrapper. It serves a RAM
// that is mirrored across the whole 64K space, a ULA-style port at even
// addresses (A[0]==0), interrupt acknowledge, and a periodic frame interrupt.
// All state advances only on clk_enable ticks. The one exception is reset,
// which is synchronous, active low, and ignores clk_enable.
//
// Optional feature macro: ZBR_WAIT_STATES_EN
//   defined   : each non-refresh access first spends WAIT_CYCLES ticks with
//               wait_n low and is performed on the tick that releases wait_n.
//   undefined : wait_n is tied high and every access is performed on the tick
//               where the request is first seen. WAIT_CYCLES is ignored.
//
// MEM_INIT names a hex memory image. The surrounding harness applies the
// preload. Without an image, the RAM contents are undefined.
module z80_bus_responder #(
    parameter int         AW          = 12,
    parameter             MEM_INIT    = "",
    parameter int         WAIT_CYCLES = 2,
    parameter int         INT_PERIOD  = 64,
    parameter int         INT_LEN     = 8,
    parameter logic [7:0] INT_VECTOR  = 8'hFF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clk_enable,
    input  logic [15:0] A,
    input  logic [7:0]  dout,
    input  logic        m1_n,
    input  logic        mreq_n,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic        rfsh_n,
    input  logic        ear_in,
    output logic [7:0]  di,
    output logic        wait_n,
    output logic        int_n,
    output logic [2:0]  border
);

    localparam int DEPTH = 1 << AW;
    localparam int FCW   = (INT_PERIOD > 2) ? $clog2(INT_PERIOD) : 1;
    localparam logic [FCW-1:0] FC_LAST    = FCW'(INT_PERIOD - 1);
    localparam logic [FCW-1:0] FC_RELEASE = FCW'(INT_LEN);

`ifdef ZBR_WAIT_STATES_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam bit WAITS_ON = (WAIT_CYCLES > 0);
    localparam int CW       = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    logic [CW-1:0] cnt_reg, cnt_next;
    logic          wait_reg, wait_next;
`else
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DONE = 1'b1
    } state_t;
`endif

    state_t state_reg, state_next;

    logic [7:0]     ram [0:DEPTH-1];
    logic [AW-1:0]  ram_addr;

    logic [7:0]     di_reg, di_next;
    logic [2:0]     border_reg, border_next;
    logic           int_reg, int_next;
    logic [FCW-1:0] fc_reg, fc_next;

    logic           is_inta, is_mem, is_io, req_valid;
    logic           do_access;
    logic           mem_we;
    logic           inta_ack;

    // Only A[0] and the low RAM bits are decoded. The rest of the address
    // is absorbed here, which is what mirrors the RAM.
    logic           unused_addr;
    assign unused_addr = &{1'b0, A[15:AW]};

    assign ram_addr = A[AW-1:0];

    // Bus cycle classification. Refresh cycles never count as requests.
    // INTA (m1_n & iorq_n low together) outranks a plain IO cycle.
    assign is_inta   = rfsh_n & ~m1_n & ~iorq_n;
    assign is_mem    = rfsh_n & ~mreq_n & (~rd_n | ~wr_n);
    assign is_io     = rfsh_n & m1_n & ~iorq_n & (~rd_n | ~wr_n);
    assign req_valid = is_inta | is_mem | is_io;

    // Bus cycle sequencing: detect a request, optionally stall, perform
    // exactly one access, then wait for the strobes to drop.
    always_comb begin
        state_next = state_reg;
        do_access  = 1'b0;
`ifdef ZBR_WAIT_STATES_EN
        cnt_next   = cnt_reg;
        wait_next  = wait_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (req_valid) begin
`ifdef ZBR_WAIT_STATES_EN
                    if (WAITS_ON) begin
                        state_next = ST_WAIT;
                        wait_next  = 1'b0;
                        cnt_next   = CW'(WAIT_CYCLES - 1);
                    end else begin
                        do_access  = 1'b1;
                        state_next = ST_DONE;
                    end
`else
                    do_access  = 1'b1;
                    state_next = ST_DONE;
`endif
                end
            end
`ifdef ZBR_WAIT_STATES_EN
            ST_WAIT: begin
                if (cnt_reg == '0) begin
                    wait_next  = 1'b1;
                    do_access  = 1'b1;
                    state_next = ST_DONE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
`endif
            ST_DONE: begin
                if (mreq_n && iorq_n) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Access actions. They use the bus as sampled on the access tick.
    // When rd_n and wr_n are both low, the cycle is treated as a read.
    always_comb begin
        di_next     = di_reg;
        border_next = border_reg;
        mem_we      = 1'b0;
        inta_ack    = 1'b0;
        if (do_access) begin
            if (is_inta) begin
                di_next  = INT_VECTOR;
                inta_ack = 1'b1;
            end else if (is_mem) begin
                if (!rd_n) begin
                    di_next = ram[ram_addr];
                end else begin
                    mem_we = 1'b1;
                end
            end else if (is_io) begin
                if (!rd_n) begin
                    di_next = A[0] ? 8'hFF : {1'b1, ear_in, 6'b111111};
                end else if (!A[0]) begin
                    border_next = dout[2:0];
                end
            end
        end
    end

    // Frame timer. int_n falls when the counter wraps and rises after
    // INT_LEN ticks or on acknowledge. A wrap on the same tick as an
    // acknowledge starts the new frame.
    always_comb begin
        fc_next  = (fc_reg == FC_LAST) ? '0 : fc_reg + 1'b1;
        int_next = int_reg;
        if (fc_next == '0) begin
            int_next = 1'b0;
        end else if (inta_ack) begin
            int_next = 1'b1;
        end else if (fc_next == FC_RELEASE) begin
            int_next = 1'b1;
        end
    end

    // State register. Reset overrides clk_enable; otherwise registers
    // update only on ticks.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg  <= ST_IDLE;
            di_reg     <= 8'hFF;
            border_reg <= 3'd0;
            int_reg    <= 1'b1;
            fc_reg     <= '0;
`ifdef ZBR_WAIT_STATES_EN
            cnt_reg    <= '0;
            wait_reg   <= 1'b1;
`endif
        end else if (clk_enable) begin
            state_reg  <= state_next;
            di_reg     <= di_next;
            border_reg <= border_next;
            int_reg    <= int_next;
            fc_reg     <= fc_next;
`ifdef ZBR_WAIT_STATES_EN
            cnt_reg    <= cnt_next;
            wait_reg   <= wait_next;
`endif
        end
    end

    // RAM write port. Reset suppresses writes, so an access that reset
    // aborts never lands.
    always_ff @(posedge clk) begin
        if (reset_n && clk_enable && mem_we) begin
            ram[ram_addr] <= dout;
        end
    end

    assign di     = di_reg;
    assign int_n  = int_reg;
    assign border = border_reg;
`ifdef ZBR_WAIT_STATES_EN
    assign wait_n = wait_reg;
`else
    assign wait_n = 1'b1;
`endif

endmodule

// File: tb/tb_z80_bus_responder.sv
// tb_z80_bus_responder
// Randomized bus traffic with a random clk_enable pattern. The bench keeps
// a behavioural model: a per-bus-cycle age count, an associative memory,
// and frame/ack arithmetic on the absolute tick count. One process compares
// the DUT outputs against that model on every falling clock edge. Directed
// scenarios add literal expectations that pin the model itself.
// Build with or without ZBR_WAIT_STATES_EN.
module tb_z80_bus_responder;

    localparam int         AW    = 12;
    localparam int         DEPTH = 1 << AW;
    localparam int         WC    = 2;
    localparam int         P     = 64;
    localparam int         LEN   = 8;
    localparam logic [7:0] VEC   = 8'hFF;
`ifdef ZBR_WAIT_STATES_EN
    localparam int EXP_WAITS = WC;
`else
    localparam int EXP_WAITS = 0;
`endif

    localparam int K_MEMWR = 0, K_MEMRD = 1, K_IOWR = 2, K_IORD = 3,
                   K_INTA  = 4, K_RFSH  = 5, K_MEMRW = 6;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        clk_enable = 1'b0;
    logic [15:0] A = 16'h0000;
    logic [7:0]  dout = 8'h00;
    logic        m1_n = 1'b1, mreq_n = 1'b1, iorq_n = 1'b1;
    logic        rd_n = 1'b1, wr_n = 1'b1, rfsh_n = 1'b1;
    logic        ear_in = 1'b0;
    logic [7:0]  di;
    logic        wait_n, int_n;
    logic [2:0]  border;

    int tests = 0;
    int fails = 0;

    z80_bus_responder #(
        .AW(AW), .MEM_INIT(""), .WAIT_CYCLES(WC),
        .INT_PERIOD(P), .INT_LEN(LEN), .INT_VECTOR(VEC)
    ) dut (
        .clk(clk), .reset_n(reset_n), .clk_enable(clk_enable),
        .A(A), .dout(dout), .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n),
        .rd_n(rd_n), .wr_n(wr_n), .rfsh_n(rfsh_n), .ear_in(ear_in),
        .di(di), .wait_n(wait_n), .int_n(int_n), .border(border)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [7:0] mem_m [int];
    bit         m_ready = 0;
    bit         m_active = 0, m_accessed = 0;
    int         m_age = 0, m_ticks = 0, m_ack_frame = -1;
    logic [7:0] m_di = 8'hFF;
    bit         m_di_known = 1;
    logic [2:0] m_border = 3'd0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_access();
        int idx;
        idx = int'(A) % DEPTH;
        if (!m1_n && !iorq_n) begin
            m_di = VEC; m_di_known = 1;
            if (m_ticks % P != 0) m_ack_frame = m_ticks / P;
        end else if (!mreq_n) begin
            if (!rd_n) begin
                if (mem_m.exists(idx)) begin m_di = mem_m[idx]; m_di_known = 1; end
                else m_di_known = 0;
            end else begin
                mem_m[idx] = dout;
            end
        end else if (!rd_n) begin
            m_di = A[0] ? 8'hFF : {1'b1, ear_in, 6'b111111};
            m_di_known = 1;
        end else if (!A[0]) begin
            m_border = dout[2:0];
        end
    endtask

    // Model update on each rising edge: reset, or one tick of bus/frame behaviour.
    initial begin
        bit req, fire;
        forever begin
            @(posedge clk);
            if (!reset_n) begin
                m_ready = 1; m_active = 0; m_accessed = 0; m_age = 0;
                m_ticks = 0; m_ack_frame = -1;
                m_di = 8'hFF; m_di_known = 1; m_border = 3'd0;
            end else if (clk_enable && m_ready) begin
                req = rfsh_n && ((!mreq_n && (!rd_n || !wr_n)) ||
                                 (!iorq_n && (!rd_n || !wr_n)) ||
                                 (!m1_n && !iorq_n));
                m_ticks++;
                fire = 0;
                if (!m_active) begin
                    if (req) begin
                        m_active = 1; m_accessed = 0; m_age = 0;
                        fire = (EXP_WAITS == 0);
                    end
                end else if (!m_accessed) begin
                    m_age++;
                    fire = (m_age == EXP_WAITS);
                end else if (mreq_n && iorq_n) begin
                    m_active = 0;
                end
                if (fire) begin
                    m_accessed = 1;
                    model_access();
                end
            end
        end
    end

    // Compare process: check every output against the model on the falling edge.
    initial begin
        int frame, pos;
        forever begin
            @(negedge clk);
            if (m_ready) begin
                frame = m_ticks / P;
                pos   = m_ticks % P;
                if (m_di_known) chk("di", {8'h00, di}, {8'h00, m_di});
                chk("wait_n", {15'd0, wait_n}, {15'd0, !(m_active && !m_accessed)});
                chk("int_n", {15'd0, int_n},
                    {15'd0, !(frame >= 1 && pos < LEN && m_ack_frame != frame)});
                chk("border", {13'd0, border}, {13'd0, m_border});
            end
        end
    end

    // Random clk_enable pattern, changed away from the active edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            clk_enable = ($urandom_range(0, 3) != 0);
        end
    end

    // Watchdog.
    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        while (clk_enable !== 1'b1) @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        m1_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1;
        rd_n = 1'b1; wr_n = 1'b1; rfsh_n = 1'b1;
    endtask

    task automatic do_reset(input int n);
        reset_n = 1'b0;
        bus_idle();
        repeat (n) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic drive(input int kind, input logic [15:0] addr, input logic [7:0] data);
        A = addr; dout = data;
        bus_idle();
        case (kind)
            K_MEMWR: begin mreq_n = 0; wr_n = 0; end
            K_MEMRD: begin mreq_n = 0; rd_n = 0; m1_n = $urandom_range(0, 1); end
            K_IOWR:  begin iorq_n = 0; wr_n = 0; end
            K_IORD:  begin iorq_n = 0; rd_n = 0; end
            K_INTA:  begin iorq_n = 0; m1_n = 0; end
            K_RFSH:  begin mreq_n = 0; rfsh_n = 0; m1_n = 0; end
            default: begin mreq_n = 0; rd_n = 0; wr_n = 0; end
        endcase
    endtask

    // One complete bus cycle. waits = ticks wait_n was seen low. di_acc =
    // di just after the access tick. The strobes are held 'hold' extra
    // ticks with dout changed, so a repeated write would be visible.
    task automatic bus(input int kind, input logic [15:0] addr, input logic [7:0] data,
                       input int hold, output int waits, output logic [7:0] di_acc);
        drive(kind, addr, data);
        tick();
        waits = 0;
        while (wait_n === 1'b0 && waits < 20) begin
            waits++;
            tick();
        end
        di_acc = di;
        repeat (hold) begin
            dout = ~data;
            tick();
        end
        bus_idle();
        tick();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int          w, n;
        logic [7:0]  d;
        logic [11:0] pool [8];

        bus_idle();
        do_reset(3);
        chk("reset_di", {8'h00, di}, 16'h00FF);
        chk("reset_wait_n", {15'd0, wait_n}, 16'd1);
        chk("reset_int_n", {15'd0, int_n}, 16'd1);
        chk("reset_border", {13'd0, border}, 16'd0);

        // Reset in the middle of an access.
        bus(K_MEMWR, 16'h000F, 8'h11, 0, w, d);
        bus(K_IOWR, 16'h00FE, 8'h06, 0, w, d);
        drive(K_MEMWR, 16'h000F, 8'hC3);
        tick();
        do_reset(3);
        chk("midreset_di", {8'h00, di}, 16'h00FF);
        chk("midreset_wait_n", {15'd0, wait_n}, 16'd1);
        chk("midreset_int_n", {15'd0, int_n}, 16'd1);
        chk("midreset_border", {13'd0, border}, 16'd0);
        bus(K_MEMRD, 16'h000F, 8'h00, 0, w, d);
`ifdef ZBR_WAIT_STATES_EN
        chk("aborted_write", {8'h00, d}, 16'h0011);
`else
        chk("aborted_write", {8'h00, d}, 16'h00C3);
`endif

        // Write, then read back through the mirror.
        bus(K_MEMWR, 16'h000F, 8'h5A, 0, w, d);
        chk("waits_memwr", w[15:0], EXP_WAITS[15:0]);
        bus(K_MEMRD, 16'h100F, 8'h00, 0, w, d);
        chk("waits_memrd", w[15:0], EXP_WAITS[15:0]);
        chk("mirror_read", {8'h00, d}, 16'h005A);

        // ULA port: write, then read even and odd ports.
        bus(K_IOWR, 16'h00FE, 8'h05, 0, w, d);
        chk("border_write", {13'd0, border}, 16'd5);
        ear_in = 1'b0;
        bus(K_IORD, 16'h00FE, 8'h00, 0, w, d);
        chk("ula_read", {8'h00, d}, 16'h00BF);
        bus(K_IORD, 16'h00FF, 8'h00, 0, w, d);
        chk("odd_port_read", {8'h00, d}, 16'h00FF);

        // A held write must land exactly once.
        bus(K_MEMWR, 16'h0123, 8'h77, 5, w, d);
        bus(K_MEMRD, 16'h0123, 8'h00, 0, w, d);
        chk("held_write_once", {8'h00, d}, 16'h0077);

        // Refresh: no wait, di held, no write.
        bus(K_MEMRD, 16'h100F, 8'h00, 0, w, d);
        bus(K_RFSH, 16'h000F, 8'hEE, 3, w, d);
        chk("rfsh_waits", w[15:0], 16'd0);
        chk("rfsh_di_held", {8'h00, di}, 16'h005A);
        bus(K_MEMRD, 16'h000F, 8'h00, 0, w, d);
        chk("rfsh_no_write", {8'h00, d}, 16'h005A);

        // Frame interrupt timing on an idle bus after a fresh reset.
        do_reset(2);
        n = 0;
        do begin tick(); n++; end while (int_n === 1'b1 && n < 200);
        chk("int_first_fall_tick", n[15:0], 16'(P));
        n = 0;
        while (int_n === 1'b0 && n < 50) begin tick(); n++; end
        chk("int_low_ticks", n[15:0], 16'(LEN));

        // Acknowledge during the next active window.
        n = 0;
        while (int_n === 1'b1 && n < 200) begin tick(); n++; end
        chk("int_second_fall", {15'd0, int_n}, 16'd0);
        bus(K_INTA, 16'h0000, 8'h00, 0, w, d);
        chk("inta_vector", {8'h00, d}, {8'h00, VEC});
        chk("inta_releases", {15'd0, int_n}, 16'd1);

        // Randomized traffic.
        for (int i = 0; i < 8; i++) pool[i] = 12'($urandom_range(0, DEPTH - 1));
        for (int i = 0; i < 400; i++) begin
            int          kind;
            logic [15:0] addr;
            kind   = $urandom_range(0, 6);
            addr   = {4'($urandom_range(0, 15)), pool[$urandom_range(0, 7)]};
            ear_in = $urandom_range(0, 1);
            if (kind == K_IOWR || kind == K_IORD) addr[0] = $urandom_range(0, 1);
            bus(kind, addr, 8'($urandom), $urandom_range(0, 3), w, d);
            if (kind == K_RFSH) chk("rand_waits", w[15:0], 16'd0);
            else                chk("rand_waits", w[15:0], EXP_WAITS[15:0]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
